work_sequencer: RTL

Sequences the SHA-256 hashing core on behalf of the comm path. It accepts jobs from the JTAG comm core, issues single-cycle `start_mining` pulses, and tracks `miner_busy` through a small state machine. It edge-detects `got_ticket` and buffers found nonces in a FIFO toward the serial/hub sender. It sits in the `clk_dcm` domain between `jtag_core`, `sha256_top` and the nonce sender.

---
 rtl/hv_pkg.sv | 15 +
 rtl/nonce_fifo.sv | 67 ++++++
 rtl/work_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hv_pkg.sv
// Shared types and widths for the hash-side sequencing logic.
// Holds the sequencer state encoding plus nonce and drop-counter widths.
package hv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    MINING
  } work_seq_state_t;

  localparam int NONCE_W = 32;
  localparam int DROP_W  = 8;

endpackage

// File: rtl/nonce_fifo.sv
// First-word-fall-through FIFO with a registered head/valid stage.
// Ports: push/push_data in, pop in, head/valid out, full/empty out.
module nonce_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & valid;
  // A pop frees the slot the push lands in, so full+pop still accepts.
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      // Head stage reads pre-edge contents; a fresh write shows a cycle later.
      if (do_pop) begin
        valid <= (count > ONE_CNT);
        if (count > ONE_CNT) head <= mem[rd_nxt];
      end else begin
        valid <= ~empty;
        if (!empty) head <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: rtl/work_sequencer.sv
// Job sequencer for the hashing core: start pulses, busy tracking, nonce FIFO.
// Ports: job handshake, start/busy/ticket to core, nonce stream out, drop_count, fault.
// Optional start watchdog enabled by defining WORK_SEQ_WATCHDOG_EN.
module work_sequencer
  import hv_pkg::*;
#(
  parameter int NONCE_FIFO_DEPTH = 4,
  parameter int START_TIMEOUT    = 64,
  parameter int MAX_RETRIES      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_valid,
  output logic               job_ready,
  output logic               start_mining,
  input  logic               miner_busy,
  input  logic               got_ticket,
  input  logic [NONCE_W-1:0] core_nonce,
  output logic               nonce_valid,
  output logic [NONCE_W-1:0] nonce_data,
  input  logic               nonce_ready,
  output logic               job_done,
  output logic [DROP_W-1:0]  drop_count,
  output logic               fault
);

  work_seq_state_t state;

  logic tkt_q;
  logic push;
  logic fifo_full;
  logic fifo_empty;
  logic drop;
  logic unused_empty;

  assign unused_empty = fifo_empty;

`ifdef WORK_SEQ_WATCHDOG_EN
  localparam int TW = $clog2(START_TIMEOUT) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;

  logic [TW-1:0] wd_cnt;
  logic [RW-1:0] retries;
  logic          fault_q;

  assign fault = fault_q;
`else
  logic [31:0] unused_cfg;

  assign unused_cfg = START_TIMEOUT ^ MAX_RETRIES;
  assign fault      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      job_ready    <= 1'b1;
      start_mining <= 1'b0;
      job_done     <= 1'b0;
`ifdef WORK_SEQ_WATCHDOG_EN
      wd_cnt       <= '0;
      retries      <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      start_mining <= 1'b0;
      job_done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (job_valid) begin
            state     <= START;
            job_ready <= 1'b0;
`ifdef WORK_SEQ_WATCHDOG_EN
            retries   <= '0;
`endif
          end
        end
        START: begin
          state        <= WAIT_BUSY;
          start_mining <= 1'b1;
          job_ready    <= 1'b0;
`ifdef WORK_SEQ_WATCHDOG_EN
          wd_cnt       <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (miner_busy) begin
            state     <= MINING;
            job_ready <= 1'b1;
`ifdef WORK_SEQ_WATCHDOG_EN
            retries   <= '0;
          end else if (wd_cnt == TW'(START_TIMEOUT - 1)) begin
            if (retries == RW'(MAX_RETRIES)) begin
              state     <= IDLE;
              job_ready <= 1'b1;
              fault_q   <= 1'b1;
            end else begin
              state   <= START;
              retries <= retries + RW'(1);
            end
          end else begin
            wd_cnt <= wd_cnt + TW'(1);
`endif
          end
        end
        MINING: begin
          // A new job wins over a same-cycle busy fall: no job_done.
          if (job_valid) begin
            state     <= START;
            job_ready <= 1'b0;
`ifdef WORK_SEQ_WATCHDOG_EN
            retries   <= '0;
`endif
          end else if (!miner_busy) begin
            state     <= IDLE;
            job_ready <= 1'b1;
            job_done  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          job_ready <= 1'b1;
        end
      endcase
    end
  end

  // tkt_q resets high so a ticket already up at release is not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tkt_q <= 1'b1;
    else        tkt_q <= got_ticket;
  end

  assign push = got_ticket & ~tkt_q;
  assign drop = push & fifo_full & ~(nonce_valid & nonce_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop && drop_count != {DROP_W{1'b1}}) begin
      drop_count <= drop_count + DROP_W'(1);
    end
  end

  nonce_fifo #(
    .DEPTH (NONCE_FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (core_nonce),
    .pop       (nonce_ready),
    .head      (nonce_data),
    .valid     (nonce_valid),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
